arm_mem: RTL and testbench
==========================

# arm_mem

Memory subsystem sitting directly downstream of the multicycle ARM core. It consumes the core's `Adr`/`WriteData`/`MemWrite` bus and returns `ReadData`. It holds a unified instruction/data word RAM plus a small MMIO window:
- an 8-bit GPIO register
- a byte-wide TX FIFO with a valid/ready drain port
- a status register
- a free-running cycle counter

## Interface
Parameters:
- `DEPTH_LOG2`, 6, log2 of RAM depth in 32-bit words (64 words).
- `FIFO_LOG2`, 2, log2 of TX FIFO depth in bytes (4 entries).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  write strobe from core.
- `Adr`  in  32  byte address from core.
- `WriteData`  in  32  write data from core.
- `ReadData`  out  32  read data to core (combinational).
- `gpio_out`  out  8  GPIO register contents.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  downstream accepts head byte.

## Operation
- Decode uses `Adr[31:28]`:
  - Any value other than 4'hF selects RAM. Word index is `Adr[DEPTH_LOG2+1:2]`; upper bits alias.
  - 4'hF selects MMIO. Register is `Adr[3:2]`; `Adr[27:4]` is ignored (aliases).
  - `Adr[1:0]` is always ignored; word access only.
- RAM:
  - Read is asynchronous.
  - Write is synchronous when `MemWrite`=1.
  - Contents are not reset.
- MMIO map:
  - 0 GPIO: read/write. Write loads `WriteData[7:0]`. Read returns `{24'b0, gpio}`.
  - 1 TXDATA: write pushes `WriteData[7:0]` into the FIFO. Read returns 0.
  - 2 STATUS, read: `[0]` empty, `[1]` full, `[FIFO_LOG2+4:2]` occupancy count, `[FIFO_LOG2+5]` sticky overflow, other bits 0.
  - 2 STATUS, write: `WriteData[FIFO_LOG2+5]`=1 clears overflow; all other bits ignored.
  - 3 CYCCNT: read returns the counter. Any write clears it.
- TX FIFO:
  - Circular buffer with read/write pointers one bit wider than `FIFO_LOG2`.
  - Push: TXDATA write while not full.
  - Push while full: data dropped, overflow set, pointers unchanged.
  - Pop: `tx_valid` && `tx_ready`.
  - Full/empty evaluated on pre-edge state:
    - Push and pop in the same cycle while full: pop occurs, push is dropped, overflow is set.
    - Push and pop in the same cycle while empty: push only, since `tx_valid`=0.
    - Otherwise simultaneous push and pop both occur and occupancy is unchanged.
  - `tx_valid` = !empty. `tx_data` = head byte when non-empty, 8'h00 when empty.
  - `tx_data` must hold stable while `tx_valid`=1 and `tx_ready`=0.
- Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF→0. A CYCCNT write loads 0 on that edge; the write takes precedence over the increment.

## Timing
- Reset (`reset`=0, asynchronous):
  - `gpio_out`=0, FIFO pointers=0, `tx_valid`=0, `tx_data`=0, overflow=0, counter=0.
  - RAM is untouched.
  - `ReadData` reflects the reset MMIO values, or current RAM contents.
  - Reset asserted mid-operation discards FIFO contents immediately.
- Read latency is 0 cycles; `ReadData` follows `Adr` combinationally. The core registers it.
- Write takes effect on the rising edge where `MemWrite`=1. Readback is visible from the next cycle.
- Status read in the cycle of a push or pop reflects pre-edge state.
- FIFO latency: a byte pushed at edge N shows `tx_valid`=1 after edge N; it can pop at edge N+1 at the earliest.
- Throughput: one pop per cycle.
- CYCCNT read after a clear at edge N returns 0 in cycle N+1 and 1 in cycle N+2.

## Configuration
- `ARM_MEM_CYCCNT_EN` defined: the cycle counter is built as described.
- `ARM_MEM_CYCCNT_EN` undefined: no counter register. CYCCNT reads return 32'h0 and writes are ignored. All other behaviour is identical.

## Test plan
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0110 (alias with `DEPTH_LOG2`=6) → 0xDEADBEEF.
- GPIO: write 0x1234_56A5 to 0xF000_0000 → `gpio_out`=0xA5, readback 0x0000_00A5. Assert reset → `gpio_out`=0x00 immediately, with no clock edge.
- FIFO fill/overflow: `tx_ready`=0, push 0x11,0x22,0x33,0x44,0x55 → STATUS = full, count=4, overflow=1. Then `tx_ready`=1 → drains 0x11,0x22,0x33,0x44 on four consecutive edges, then `tx_valid`=0 and `tx_data`=0x00.
- Simultaneous push/pop: with 2 entries and `tx_ready`=1, push 0x66 → count stays 2 and order is preserved. While full with `tx_ready`=1, push → pop occurs, push dropped, overflow=1. Write STATUS with the overflow bit set → overflow=0.
- Cycle counter (`ARM_MEM_CYCCNT_EN` defined): write to 0xF000_000C, then successive reads return 0,1,2. Force counter to 0xFFFFFFFF → next read 0x00000000. With the macro undefined, reads always return 0.

Source files
------------

// File: rtl/arm_mem.sv
// arm_mem: unified instruction/data word RAM plus an MMIO window (GPIO, TX FIFO,
// STATUS, CYCCNT) sitting directly behind the multicycle ARM core.
// Optional feature: define ARM_MEM_CYCCNT_EN to build the free-running cycle
// counter. Without it, CYCCNT reads as zero and writes to it are ignored.
module arm_mem #(
  parameter int DEPTH_LOG2 = 6,
  parameter int FIFO_LOG2  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_LOG2;

  localparam logic [1:0] REG_GPIO   = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CYCCNT = 2'd3;

  localparam logic [FIFO_LOG2:0] PTR_ONE = 1;

  // Address decode: top nibble 4'hF is MMIO, everything else aliases into RAM.
  logic                  is_mmio;
  logic [1:0]            reg_sel;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  unused_adr;

  assign is_mmio    = (Adr[31:28] == 4'hF);
  assign reg_sel    = Adr[3:2];
  assign word_idx   = Adr[DEPTH_LOG2+1:2];
  assign unused_adr = ^{Adr[27:4], Adr[1:0]};

  logic ram_we, gpio_we, push_req, status_we;

  assign ram_we    = MemWrite && !is_mmio;
  assign gpio_we   = MemWrite && is_mmio && (reg_sel == REG_GPIO);
  assign push_req  = MemWrite && is_mmio && (reg_sel == REG_TXDATA);
  assign status_we = MemWrite && is_mmio && (reg_sel == REG_STATUS);

  // Word RAM: asynchronous read, synchronous write, contents never reset.
  logic [31:0] ram_q [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[word_idx] <= WriteData;
  end

  // TX FIFO bookkeeping; the extra pointer bit distinguishes full from empty.
  logic [7:0]         fifo_q [FIFO_DEPTH];
  logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic               empty, full, push, pop;
  logic               ovf_q, ovf_d;
  logic [7:0]         gpio_q, gpio_d;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                    (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q[FIFO_LOG2-1:0]];
  assign pop      = tx_valid && tx_ready;
  assign push     = push_req && !full;
  assign gpio_out = gpio_q;

  // FIFO storage write; a push into a full FIFO never reaches the array.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[FIFO_LOG2-1:0]] <= WriteData[7:0];
  end

  // Next-state for GPIO, FIFO pointers and the sticky overflow flag.
  always_comb begin
    gpio_d   = gpio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (gpio_we) gpio_d = WriteData[7:0];
    if (push)    wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (status_we && WriteData[FIFO_LOG2+5]) begin
      ovf_d = 1'b0;
    end
  end

  // MMIO state register; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  logic [31:0] cyc_rd;

`ifdef ARM_MEM_CYCCNT_EN
  logic        cyc_we;
  logic [31:0] cyc_q, cyc_d;

  assign cyc_we = MemWrite && is_mmio && (reg_sel == REG_CYCCNT);
  assign cyc_rd = cyc_q;

  // Free-running counter; a CYCCNT write wins over the increment.
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (cyc_we) cyc_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end
`else
  assign cyc_rd = '0;
`endif

  // Status word assembled from pre-edge FIFO state.
  logic [31:0] status;

  always_comb begin
    status                      = '0;
    status[0]                   = empty;
    status[1]                   = full;
    status[FIFO_LOG2+4:2]       = {2'b00, count};
    status[FIFO_LOG2+5]         = ovf_q;
  end

  // Combinational read mux back to the core.
  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram_q[word_idx];
    end else begin
      case (reg_sel)
        REG_GPIO:   ReadData = {24'b0, gpio_q};
        REG_TXDATA: ReadData = '0;
        REG_STATUS: ReadData = status;
        REG_CYCCNT: ReadData = cyc_rd;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mem.sv
// tb_arm_mem: directed, table-driven bench for arm_mem (default parameters).
// The CYCCNT section follows the same ARM_MEM_CYCCNT_EN macro as the design.
module tb_arm_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  arm_mem dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Adr      (Adr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .gpio_out (gpio_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpio;
    logic        exp_valid;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                              input logic rdy, input logic chk_rd, input logic [31:0] exp_rd,
                              input logic [7:0] exp_gpio, input logic exp_valid,
                              input logic [7:0] exp_txd);
    vec_t v;
    v.we = we; v.adr = adr; v.wdata = wdata; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_gpio = exp_gpio;
    v.exp_valid = exp_valid; v.exp_txd = exp_txd;
    return v;
  endfunction

  task automatic checkOutput(input string what, input int idx, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", what, idx, actual, expected);
    end
  endtask

  // Drive one bus cycle after the falling edge; outputs settle well before the next rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                               input logic rdy);
    @(negedge clk);
    MemWrite  = we;
    Adr       = adr;
    WriteData = wdata;
    tx_ready  = rdy;
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; MemWrite = 1'b0; Adr = 32'h0; WriteData = 32'h0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    Adr = 32'hF000_0008;
    #1;
    checkOutput("reset gpio_out", -1, {24'b0, gpio_out}, 32'h0);
    checkOutput("reset tx_valid", -1, {31'b0, tx_valid}, 32'h0);
    checkOutput("reset tx_data",  -1, {24'b0, tx_data},  32'h0);
    checkOutput("reset STATUS",   -1, ReadData,          32'h1);
    @(negedge clk);
    reset = 1'b1;

    //              we    adr           wdata         rdy  chk  exp_rd        gpio   v     txd
    vecs.push_back(mk(1, 32'h0000_0010, 32'hDEADBEEF, 0, 0, 32'h0,         8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 32'h0000_0010, 32'h0,        0, 1, 32'hDEADBEEF,  8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 32'h0000_0110, 32'h0,        0, 1, 32'hDEADBEEF,  8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 32'h8000_0010, 32'h0,        0, 1, 32'hDEADBEEF,  8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 32'hF000_0000, 32'h123456A5, 0, 1, 32'h0,         8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 32'hF000_0000, 32'h0,        0, 1, 32'h0000_00A5, 8'hA5, 0, 8'h00));
    vecs.push_back(mk(0, 32'hFABC_DEF3, 32'h0,        0, 1, 32'h0000_00A5, 8'hA5, 0, 8'h00));
    vecs.push_back(mk(1, 32'h0000_0000, 32'hCAFEF00D, 0, 0, 32'h0,         8'hA5, 0, 8'h00));
    vecs.push_back(mk(1, 32'hF000_0000, 32'h0000003C, 0, 1, 32'h0000_00A5, 8'hA5, 0, 8'h00));
    vecs.push_back(mk(0, 32'h0000_0000, 32'h0,        0, 1, 32'hCAFEF00D,  8'h3C, 0, 8'h00));
    // Fill with tx_ready low, fifth push overflows.
    vecs.push_back(mk(1, 32'hF000_0004, 32'h11,       0, 1, 32'h0,         8'h3C, 0, 8'h00));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h22,       0, 1, 32'h0,         8'h3C, 1, 8'h11));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h33,       0, 1, 32'h0,         8'h3C, 1, 8'h11));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h44,       0, 1, 32'h0,         8'h3C, 1, 8'h11));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h55,       0, 1, 32'h0,         8'h3C, 1, 8'h11));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        0, 1, 32'h92,        8'h3C, 1, 8'h11));
    // Drain one byte per edge while reading STATUS.
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        1, 1, 32'h92,        8'h3C, 1, 8'h11));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        1, 1, 32'h8C,        8'h3C, 1, 8'h22));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        1, 1, 32'h88,        8'h3C, 1, 8'h33));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        1, 1, 32'h84,        8'h3C, 1, 8'h44));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        1, 1, 32'h81,        8'h3C, 0, 8'h00));
    // Simultaneous push/pop with two entries.
    vecs.push_back(mk(1, 32'hF000_0004, 32'h77,       0, 1, 32'h0,         8'h3C, 0, 8'h00));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h88,       0, 1, 32'h0,         8'h3C, 1, 8'h77));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h66,       1, 1, 32'h0,         8'h3C, 1, 8'h77));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        0, 1, 32'h88,        8'h3C, 1, 8'h88));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        1, 1, 32'h88,        8'h3C, 1, 8'h88));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        0, 1, 32'h84,        8'h3C, 1, 8'h66));
    vecs.push_back(mk(1, 32'hF000_0004, 32'h99,       0, 1, 32'h0,         8'h3C, 1, 8'h66));
    vecs.push_back(mk(1, 32'hF000_0004, 32'hAA,       0, 1, 32'h0,         8'h3C, 1, 8'h66));
    vecs.push_back(mk(1, 32'hF000_0004, 32'hBB,       0, 1, 32'h0,         8'h3C, 1, 8'h66));
    // Clear overflow, then push+pop while full.
    vecs.push_back(mk(1, 32'hF000_0008, 32'h80,       0, 1, 32'h92,        8'h3C, 1, 8'h66));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        0, 1, 32'h12,        8'h3C, 1, 8'h66));
    vecs.push_back(mk(1, 32'hF000_0004, 32'hCC,       1, 1, 32'h0,         8'h3C, 1, 8'h66));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        0, 1, 32'h8C,        8'h3C, 1, 8'h99));
    vecs.push_back(mk(1, 32'hF000_0008, 32'h7F,       0, 1, 32'h8C,        8'h3C, 1, 8'h99));
    vecs.push_back(mk(0, 32'hF000_0008, 32'h0,        0, 1, 32'h8C,        8'h3C, 1, 8'h99));
    vecs.push_back(mk(1, 32'hF000_0008, 32'h80,       0, 1, 32'h8C,        8'h3C, 1, 8'h99));
    vecs.push_back(mk(0, 32'hFFFF_FFF8, 32'h0,        0, 1, 32'h0C,        8'h3C, 1, 8'h99));
    vecs.push_back(mk(0, 32'hF000_0004, 32'h0,        0, 1, 32'h0,         8'h3C, 1, 8'h99));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].rdy);
      if (vecs[i].chk_rd) checkOutput("ReadData", i, ReadData, vecs[i].exp_rd);
      checkOutput("gpio_out", i, {24'b0, gpio_out}, {24'b0, vecs[i].exp_gpio});
      checkOutput("tx_valid", i, {31'b0, tx_valid}, {31'b0, vecs[i].exp_valid});
      checkOutput("tx_data",  i, {24'b0, tx_data},  {24'b0, vecs[i].exp_txd});
    end

`ifdef ARM_MEM_CYCCNT_EN
    applyStimulus(1, 32'hF000_000C, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 32'hF000_000C, 32'h0, 0);
      checkOutput("CYCCNT after clear", 100 + k, ReadData, k);
    end
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    checkOutput("CYCCNT forced", 110, ReadData, 32'hFFFF_FFFF);
    release dut.cyc_q;
    applyStimulus(0, 32'hF000_000C, 32'h0, 0);
    checkOutput("CYCCNT wrap", 111, ReadData, 32'h0);
`else
    applyStimulus(1, 32'hF000_000C, 32'h1234, 0);
    checkOutput("CYCCNT disabled", 100, ReadData, 32'h0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 32'hF000_000C, 32'h0, 0);
      checkOutput("CYCCNT disabled", 101 + k, ReadData, 32'h0);
    end
    checkOutput("gpio after CYCCNT write", 103, {24'b0, gpio_out}, 32'h3C);
`endif

    // Asynchronous reset mid-operation: FIFO holds 99,AA,BB and GPIO is 3C.
    applyStimulus(0, 32'hF000_0008, 32'h0, 0);
    checkOutput("pre-reset tx_valid", 200, {31'b0, tx_valid}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("async reset gpio_out", 201, {24'b0, gpio_out}, 32'h0);
    checkOutput("async reset tx_valid", 202, {31'b0, tx_valid}, 32'h0);
    checkOutput("async reset tx_data",  203, {24'b0, tx_data},  32'h0);
    checkOutput("async reset STATUS",   204, ReadData,          32'h1);
    Adr = 32'h0000_0010;
    #1;
    checkOutput("RAM kept in reset", 205, ReadData, 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 32'h0000_0000, 32'h0, 1);
    checkOutput("RAM after reset", 206, ReadData, 32'hCAFEF00D);
    checkOutput("tx_valid after reset", 207, {31'b0, tx_valid}, 32'h0);
    applyStimulus(0, 32'hF000_0008, 32'h0, 0);
    checkOutput("STATUS after reset", 208, ReadData, 32'h1);

    MemWrite = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
